lsu_dc_arbiter: RTL and testbench
=================================

Name: lsu_dc_arbiter

Overview:
- Owns the single data-cache access port in the LSU.
- Arbitrates each cycle between three requesters: MHQ line fills, retiring stores from the store queue, and loads from LSU_ID.
- Generates the store-queue retire stall, and later the store-queue update/retry handshake from the cache response.
- Bounds store starvation behind loads with an age counter.

Parameters:
- DC_LATENCY, 1: cycles from a store grant to its hit/MHQ-full response (1..4).
- STARVE_LIMIT, 8: consecutive denied store cycles before the store beats loads (2..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_flush  in  1  pipeline flush
- i_fill_req  in  1  MHQ fill write request (never back-pressured)
- i_ld_req  in  1  load wants the D$ port
- o_ld_grant  out  1  load granted this cycle
- i_sq_retire_req  in  1  SQ holds a retirable store (OR of its retirable vector)
- o_sq_retire_stall  out  1  SQ must not launch a store this cycle
- o_dc_en  out  1  D$ port active this cycle
- o_dc_sel  out  2  dc_sel_t: DC_SEL_NONE=0, FILL=1, LOAD=2, STORE=3
- i_dc_st_hit  in  1  store response: hit
- i_mhq_full  in  1  store response: MHQ cannot take a miss
- o_update_sq_en  out  1  store outcome valid
- o_update_sq_retry  out  1  store must be relaunched

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. In reset cycles all registered state clears.
- Outputs during reset:
  - o_ld_grant=0, o_dc_en=0, o_dc_sel=NONE
  - o_sq_retire_stall=1
  - o_update_sq_en=0, o_update_sq_retry=0
- Store eligibility: store_ok = i_sq_retire_req && ~st_busy_blocking.
  - st_busy is set on a store grant.
  - st_busy clears in the cycle the response is consumed.
  - A new store may be granted in that same response cycle, so DC_LATENCY=1 sustains back-to-back stores.
- Priority, fully combinational, one grant per cycle:
  1. Fill.
  2. Store, if store_ok and starve_cnt >= STARVE_LIMIT.
  3. Load, if i_ld_req && ~i_flush.
  4. Store, if store_ok.
  5. None.
- Grant outputs:
  - o_dc_en = (sel != NONE).
  - o_ld_grant = (sel == LOAD).
  - o_sq_retire_stall = (sel != STORE).
- A flush blocks load grants only. Stores in the SQ are non-speculative, and fills are unaffected.
- starve_cnt (8-bit, saturating):
  - Clears on a store grant or when ~i_sq_retire_req.
  - Otherwise increments while store_ok and not granted.
  - Holds while the store is blocked by st_busy.
- Response pipeline: valid shift register of depth DC_LATENCY; bit 0 is loaded by a store grant. When the last stage is valid:
  - o_update_sq_en=1 that cycle (combinational from the stage and response inputs).
  - o_update_sq_retry = ~i_dc_st_hit && i_mhq_full.
  - Hit, or miss accepted by the MHQ: retry=0.
- Only one store is in flight, so the shift register holds at most one set bit.
- Reset mid-operation: an in-flight store is dropped and no update is emitted. The SQ is reset in the same cycle.
- A flush never cancels an in-flight store response.

Decomposition:
- Shared package (procyon_types): dc_sel_t enum and its 2-bit width.
- One sub-module, lsu_dc_resp_pipe: the parameterised valid shift register that raises resp_valid after DC_LATENCY cycles.
- Priority logic and starve counter stay in the top module.

Test Plan:
- Reset: hold rst 2 cycles with all requests high -> stall=1, grants 0, update_en=0. First cycle after reset with fill=1 -> sel=FILL.
- Priority: fill+load+store same cycle -> FILL. Next cycle load+store -> LOAD, stall=1. Next cycle store only -> STORE, stall=0.
- Starvation, STARVE_LIMIT=8: load and store requesting every cycle -> 8 LOAD grants, then STORE on cycle 9, starve_cnt back to 0.
- Response, DC_LATENCY=2: store granted at cycle T, response at T+2 with hit=0, mhq_full=1 -> update_en=1, retry=1 at T+2. No store grant at T+1. Store grant allowed at T+2.
- Back-to-back, DC_LATENCY=1: store_req held 4 cycles, no loads -> 4 consecutive STORE grants and 4 updates, each one cycle after its grant.
- Flush: i_flush=1 with load and store requesting -> STORE granted, o_ld_grant=0. An in-flight store update still appears on schedule.

Source files
------------

// File: rtl/procyon_types.sv
// Shared LSU types: data-cache port select encoding.
package procyon_types;

  localparam int unsigned DC_SEL_W = 2;

  typedef enum logic [DC_SEL_W-1:0] {
    DC_SEL_NONE  = 2'd0,
    DC_SEL_FILL  = 2'd1,
    DC_SEL_LOAD  = 2'd2,
    DC_SEL_STORE = 2'd3
  } dc_sel_t;

endpackage

// File: rtl/lsu_dc_resp_pipe.sv
// Valid shift register that flags a store response DEPTH cycles after the grant.
module lsu_dc_resp_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  output logic resp_valid
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d    = '0;
    stage_d[0] = push;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign resp_valid = stage_q[DEPTH-1];

endmodule

// File: rtl/lsu_dc_arbiter.sv
// Single D$ port arbiter: fill > starved store > load > store, with store
// response tracking and SQ update/retry signalling.
module lsu_dc_arbiter
  import procyon_types::*;
#(
  parameter int unsigned DC_LATENCY   = 1,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_flush,
  input  logic    i_fill_req,
  input  logic    i_ld_req,
  output logic    o_ld_grant,
  input  logic    i_sq_retire_req,
  output logic    o_sq_retire_stall,
  output logic    o_dc_en,
  output dc_sel_t o_dc_sel,
  input  logic    i_dc_st_hit,
  input  logic    i_mhq_full,
  output logic    o_update_sq_en,
  output logic    o_update_sq_retry
);

  localparam logic [7:0] STARVE_LIM = STARVE_LIMIT[7:0];

  dc_sel_t    sel;
  logic       store_ok;
  logic       st_grant;
  logic       resp_valid;
  logic       st_busy_q, st_busy_d;
  logic [7:0] starve_q, starve_d;

  // The busy flag releases in the response cycle so a new store can launch then.
  assign store_ok = i_sq_retire_req && !(st_busy_q && !resp_valid);

  always_comb begin
    sel = DC_SEL_NONE;
    if (rst) begin
      sel = DC_SEL_NONE;
    end else if (i_fill_req) begin
      sel = DC_SEL_FILL;
    end else if (store_ok && (starve_q >= STARVE_LIM)) begin
      sel = DC_SEL_STORE;
    end else if (i_ld_req && !i_flush) begin
      sel = DC_SEL_LOAD;
    end else if (store_ok) begin
      sel = DC_SEL_STORE;
    end
  end

  assign st_grant = (sel == DC_SEL_STORE);

  always_comb begin
    st_busy_d = st_busy_q;
    if (st_grant) begin
      st_busy_d = 1'b1;
    end else if (resp_valid) begin
      st_busy_d = 1'b0;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (st_grant || !i_sq_retire_req) begin
      starve_d = 8'd0;
    end else if (store_ok && (starve_q != 8'hFF)) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_busy_q <= 1'b0;
      starve_q  <= 8'd0;
    end else begin
      st_busy_q <= st_busy_d;
      starve_q  <= starve_d;
    end
  end

  lsu_dc_resp_pipe #(
    .DEPTH(DC_LATENCY)
  ) u_resp_pipe (
    .clk       (clk),
    .rst       (rst),
    .push      (st_grant),
    .resp_valid(resp_valid)
  );

  assign o_dc_sel          = sel;
  assign o_dc_en           = (sel != DC_SEL_NONE);
  assign o_ld_grant        = (sel == DC_SEL_LOAD);
  assign o_sq_retire_stall = (sel != DC_SEL_STORE);

  // Stage contents are stale during a reset cycle; suppress them.
  assign o_update_sq_en    = resp_valid && !rst;
  assign o_update_sq_retry = o_update_sq_en && !i_dc_st_hit && i_mhq_full;

endmodule

// File: tb/tb_lsu_dc_arbiter.sv
// Scoreboard bench for lsu_dc_arbiter at DC_LATENCY 1 and 2 with shared stimulus.
module tb_lsu_dc_arbiter;
  import procyon_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0, fill = 1'b0, ld = 1'b0, sq = 1'b0, hit = 1'b0, mfull = 1'b0;

  logic    ldg [2];
  logic    stall [2];
  logic    dcen [2];
  dc_sel_t sel [2];
  logic    upd [2];
  logic    retry [2];

  always #5 clk = ~clk;

  lsu_dc_arbiter #(.DC_LATENCY(1), .STARVE_LIMIT(8)) dut1 (
    .clk(clk), .rst(rst), .i_flush(flush), .i_fill_req(fill), .i_ld_req(ld),
    .o_ld_grant(ldg[0]), .i_sq_retire_req(sq), .o_sq_retire_stall(stall[0]),
    .o_dc_en(dcen[0]), .o_dc_sel(sel[0]), .i_dc_st_hit(hit), .i_mhq_full(mfull),
    .o_update_sq_en(upd[0]), .o_update_sq_retry(retry[0])
  );

  lsu_dc_arbiter #(.DC_LATENCY(2), .STARVE_LIMIT(8)) dut2 (
    .clk(clk), .rst(rst), .i_flush(flush), .i_fill_req(fill), .i_ld_req(ld),
    .o_ld_grant(ldg[1]), .i_sq_retire_req(sq), .o_sq_retire_stall(stall[1]),
    .o_dc_en(dcen[1]), .o_dc_sel(sel[1]), .i_dc_st_hit(hit), .i_mhq_full(mfull),
    .o_update_sq_en(upd[1]), .o_update_sq_retry(retry[1])
  );

  typedef struct {
    int         d;
    logic [1:0] sel;
    logic       upd;
    logic       retry;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, req);
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, " sel"}, logic'(sel[e.d]) ? 2'(sel[e.d]) : 2'(sel[e.d]), e.sel);
      chk({e.name, " ld_grant"}, {1'b0, ldg[e.d]}, {1'b0, e.sel == 2'd2});
      chk({e.name, " stall"}, {1'b0, stall[e.d]}, {1'b0, e.sel != 2'd3});
      chk({e.name, " dc_en"}, {1'b0, dcen[e.d]}, {1'b0, e.sel != 2'd0});
      chk({e.name, " upd_en"}, {1'b0, upd[e.d]}, {1'b0, e.upd});
      chk({e.name, " retry"}, {1'b0, retry[e.d]}, {1'b0, e.retry});
    end
  end

  // Inputs: d rst fill ld sq flush hit mfull; expected sel, update_en, retry.
  task automatic step(input int d, input logic r, input logic f, input logic l,
                      input logic s, input logic fl, input logic h, input logic m,
                      input logic [1:0] es, input logic eu, input logic er,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; fill = f; ld = l; sq = s; flush = fl; hit = h; mfull = m;
    e.d = d; e.sel = es; e.upd = eu; e.retry = er; e.name = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset and basic priority on the latency-1 instance.
    step(0, 1, 1, 1, 1, 0, 1, 0, 2'd0, 0, 0, "rst0");
    step(0, 1, 1, 1, 1, 0, 1, 0, 2'd0, 0, 0, "rst1");
    step(0, 0, 1, 1, 1, 0, 1, 0, 2'd1, 0, 0, "fill_all");
    step(0, 0, 0, 1, 1, 0, 1, 0, 2'd2, 0, 0, "load_over_store");
    step(0, 0, 0, 0, 1, 0, 1, 0, 2'd3, 0, 0, "store_only");
    step(0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 1, 0, "store_hit_upd");
    step(0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 0, "idle");

    // Starvation: 8 loads win, then the store.
    step(0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, "starve_rst");
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 1, 0, 1, 0, 2'd2, 0, 0, $sformatf("starve_ld%0d", i));
    end
    step(0, 0, 0, 1, 1, 0, 1, 0, 2'd3, 0, 0, "starve_store");
    step(0, 0, 0, 1, 1, 0, 1, 0, 2'd2, 1, 0, "starve_cleared");
    step(0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 0, "starve_idle");

    // Back-to-back stores at latency 1.
    step(0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, "b2b_rst");
    step(0, 0, 0, 0, 1, 0, 1, 0, 2'd3, 0, 0, "b2b_st0");
    step(0, 0, 0, 0, 1, 0, 1, 0, 2'd3, 1, 0, "b2b_st1");
    step(0, 0, 0, 0, 1, 0, 1, 0, 2'd3, 1, 0, "b2b_st2");
    step(0, 0, 0, 0, 1, 0, 1, 0, 2'd3, 1, 0, "b2b_st3");
    step(0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 1, 0, "b2b_upd3");
    step(0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 0, "b2b_idle");

    // Flush blocks loads only; in-flight response still reported.
    step(0, 0, 0, 0, 1, 0, 1, 0, 2'd3, 0, 0, "fl_store");
    step(0, 0, 0, 1, 0, 1, 0, 1, 2'd0, 1, 1, "fl_noload_retry");
    step(0, 0, 0, 1, 1, 1, 1, 0, 2'd3, 0, 0, "fl_store_wins");
    step(0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 1, 0, "fl_upd");

    // Reset while a store is in flight drops its update.
    step(0, 0, 0, 0, 1, 0, 1, 0, 2'd3, 0, 0, "mid_store");
    step(0, 1, 1, 1, 1, 0, 1, 0, 2'd0, 0, 0, "mid_rst");
    step(0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 0, "mid_dropped");

    // Latency-2 instance: response timing and retry decode.
    step(1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, "l2_rst");
    step(1, 0, 0, 0, 1, 0, 1, 0, 2'd3, 0, 0, "l2_store_t");
    step(1, 0, 0, 0, 1, 0, 1, 0, 2'd0, 0, 0, "l2_busy_t1");
    step(1, 0, 0, 0, 1, 0, 0, 1, 2'd3, 1, 1, "l2_retry_t2");
    step(1, 0, 0, 0, 0, 0, 1, 1, 2'd0, 0, 0, "l2_wait");
    step(1, 0, 0, 0, 0, 0, 1, 1, 2'd0, 1, 0, "l2_hit_wins");
    step(1, 0, 0, 0, 1, 0, 0, 0, 2'd3, 0, 0, "l2_store2");
    step(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, "l2_wait2");
    step(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0, "l2_miss_accepted");
    step(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, "l2_idle");

    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
